// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: state encodings, default
// vectors and PC helpers.
package pc_fetch_ctrl_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_WAIT_ID = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_t;

  // Word-align a branch target by clearing the two low bits.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the IF/ID
// valid/ready hand-off. The master side is the fetch sequencer.
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;

  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_pc;
  logic [INST_W-1:0] id_inst;

  modport master (
    output imem_req, imem_addr, id_valid, id_pc, id_inst,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_pc, id_inst,
    output imem_ack, imem_rdata, id_ready
  );

endinterface

// File: rtl/pc_fetch_ctrl_out_reg.sv
// Valid/ready output register between fetch and decode. Holds one
// instruction with its PC; a flush empties it without touching the data.
module fetch_out_reg
  import pc_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              cap,
  input  logic [31:0]       cap_pc,
  input  logic [INST_W-1:0] cap_inst,
  input  logic              ready,
  output logic              valid,
  output logic [31:0]       pc,
  output logic [INST_W-1:0] inst
);

  // Load on capture, drop on flush or consumption, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      pc    <= '0;
      inst  <= '0;
    end else begin
      if (cap) begin
        pc   <= cap_pc;
        inst <= cap_inst;
      end
      if (flush)
        valid <= 1'b0;
      else if (cap)
        valid <= 1'b1;
      else if (valid && ready)
        valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one instruction-memory read at a
// time, applies redirects/traps/halt and hands fetched words to decode.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_fetch_ctrl_if.master      bus,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic                 trap,
  input  logic                 halt,
  output logic                 halted
);

  fetch_state_t state, state_nxt;
  logic [31:0]  pc;
  logic [31:0]  addr_q;   // address of the request currently on the bus
  logic         busy;     // a request was issued earlier and is still unacked
  logic         kill;     // the outstanding request belongs to a stale path
  logic         redir;
  logic         issue_ok;
  logic         cap;

  assign redir    = (redirect || trap) && (state != ST_BOOT);
  assign issue_ok = !bus.id_valid || bus.id_ready;

  // An unacked request is never withdrawn; a new one needs room downstream.
  assign bus.imem_req  = busy || ((state == ST_FETCH) && !halt && issue_ok);
  assign bus.imem_addr = busy ? addr_q : pc;
  assign cap           = bus.imem_req && bus.imem_ack && !kill && !redir;
  assign halted        = (state == ST_HALT) && !busy && halt;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_nxt;
  end

  // Next-state selection; a redirect or trap always restarts the sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT:    state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (busy) begin
          if (bus.imem_ack && halt) state_nxt = ST_HALT;
        end else if (halt) begin
          state_nxt = ST_HALT;
        end else if (!issue_ok) begin
          state_nxt = ST_WAIT_ID;
        end
      end
      ST_WAIT_ID: if (bus.id_ready) state_nxt = ST_FETCH;
      ST_HALT:    if (!halt) state_nxt = ST_FETCH;
      default:    state_nxt = ST_BOOT;
    endcase
    if (redir) state_nxt = halt ? ST_HALT : ST_FETCH;
  end

  // PC, outstanding-request and kill tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= RESET_PC;
      busy <= 1'b0;
      kill <= 1'b0;
    end else begin
      if (redir)
        pc <= trap ? TRAP_VEC : align_pc(redirect_pc);
      else if (cap)
        pc <= bus.imem_addr + PC_STEP;
      busy <= bus.imem_req && !bus.imem_ack;
      if (redir && bus.imem_req && !bus.imem_ack)
        kill <= 1'b1;
      else if (bus.imem_req && bus.imem_ack)
        kill <= 1'b0;
    end
  end

  // Latch the address when a request goes unacked so it stays put even if
  // the PC is redirected underneath it.
  always_ff @(posedge clk) begin
    if (bus.imem_req && !bus.imem_ack && !busy)
      addr_q <= pc;
  end

  fetch_out_reg u_out (
    .clk      (clk),
    .reset    (reset),
    .flush    (redir),
    .cap      (cap),
    .cap_pc   (bus.imem_addr),
    .cap_inst (bus.imem_rdata),
    .ready    (bus.id_ready),
    .valid    (bus.id_valid),
    .pc       (bus.id_pc),
    .inst     (bus.id_inst)
  );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a per-cycle vector table covering
// streaming, ack stalls, decode back-pressure, redirect/trap/wrap and halt,
// followed by a hand-written reset-mid-request sequence.
module tb_pc_fetch_ctrl;
  import pc_fetch_ctrl_pkg::*;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        trap;
    logic        halt;
  } in_t;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] id_pc;
    logic [31:0] inst;
    logic        halted;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int NV = 31;

  logic clk = 1'b0;
  logic reset;
  logic redirect, trap, halt, halted;
  logic [31:0] redirect_pc;
  int passed = 0;
  int total  = 0;
  vec_t vecs [NV];

  pc_fetch_ctrl_if bus();

  pc_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .trap        (trap),
    .halt        (halt),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic ack, input logic [31:0] rdata, input logic rdy,
    input logic redir, input logic [31:0] rpc, input logic tr, input logic hl,
    input logic req, input logic [31:0] addr, input logic vld,
    input logic [31:0] ipc, input logic [31:0] inst, input logic hlt);
    vec_t v;
    v.i = '{ack: ack, rdata: rdata, rdy: rdy, redir: redir, rpc: rpc, trap: tr, halt: hl};
    v.o = '{req: req, addr: addr, vld: vld, id_pc: ipc, inst: inst, halted: hlt};
    return v;
  endfunction

  task automatic drive(input in_t i);
    bus.imem_ack   = i.ack;
    bus.imem_rdata = i.rdata;
    bus.id_ready   = i.rdy;
    redirect       = i.redir;
    redirect_pc    = i.rpc;
    trap           = i.trap;
    halt           = i.halt;
  endtask

  task automatic sample(output out_t o);
    o.req    = bus.imem_req;
    o.addr   = bus.imem_addr;
    o.vld    = bus.id_valid;
    o.id_pc  = bus.id_pc;
    o.inst   = bus.id_inst;
    o.halted = halted;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t got;
    sample(got);
    total++;
    if (got !== exp)
      $display("FAIL %s: got req=%0b addr=%h vld=%0b id_pc=%h inst=%h halted=%0b, want req=%0b addr=%h vld=%0b id_pc=%h inst=%h halted=%0b",
               name, got.req, got.addr, got.vld, got.id_pc, got.inst, got.halted,
               exp.req, exp.addr, exp.vld, exp.id_pc, exp.inst, exp.halted);
    else
      passed++;
  endtask

  initial begin
    out_t rst_o;
    //                ack rdata          rdy rd  rpc            tr hl | req addr          vld id_pc         inst          hlt
    // streaming from reset
    vecs[0]  = mk(1, 32'h0,          1, 0, 32'h0,         0, 0,  0, 32'h0,         0, 32'h0,         32'h0,         0);
    vecs[1]  = mk(1, 32'h1111_0000,  1, 0, 32'h0,         0, 0,  1, 32'h0,         0, 32'h0,         32'h0,         0);
    vecs[2]  = mk(1, 32'h1111_0004,  1, 0, 32'h0,         0, 0,  1, 32'h4,         1, 32'h0,         32'h1111_0000, 0);
    // ack delayed 3 cycles at pc=8
    vecs[3]  = mk(0, 32'h0,          1, 0, 32'h0,         0, 0,  1, 32'h8,         1, 32'h4,         32'h1111_0004, 0);
    vecs[4]  = mk(0, 32'h0,          1, 0, 32'h0,         0, 0,  1, 32'h8,         0, 32'h4,         32'h1111_0004, 0);
    vecs[5]  = mk(0, 32'h0,          1, 0, 32'h0,         0, 0,  1, 32'h8,         0, 32'h4,         32'h1111_0004, 0);
    vecs[6]  = mk(1, 32'h1111_0008,  1, 0, 32'h0,         0, 0,  1, 32'h8,         0, 32'h4,         32'h1111_0004, 0);
    // decode back-pressure
    vecs[7]  = mk(0, 32'h0,          0, 0, 32'h0,         0, 0,  0, 32'hC,         1, 32'h8,         32'h1111_0008, 0);
    vecs[8]  = mk(0, 32'h0,          0, 0, 32'h0,         0, 0,  0, 32'hC,         1, 32'h8,         32'h1111_0008, 0);
    vecs[9]  = mk(0, 32'h0,          1, 0, 32'h0,         0, 0,  0, 32'hC,         1, 32'h8,         32'h1111_0008, 0);
    vecs[10] = mk(1, 32'h1111_000C,  1, 0, 32'h0,         0, 0,  1, 32'hC,         0, 32'h8,         32'h1111_0008, 0);
    vecs[11] = mk(0, 32'h0,          1, 0, 32'h0,         0, 0,  1, 32'h10,        1, 32'hC,         32'h1111_000C, 0);
    // redirect to 0x203 with a request outstanding
    vecs[12] = mk(0, 32'h0,          1, 1, 32'h203,       0, 0,  1, 32'h10,        0, 32'hC,         32'h1111_000C, 0);
    vecs[13] = mk(0, 32'h0,          1, 0, 32'h0,         0, 0,  1, 32'h10,        0, 32'hC,         32'h1111_000C, 0);
    vecs[14] = mk(1, 32'hDEAD_BEEF,  1, 0, 32'h0,         0, 0,  1, 32'h10,        0, 32'hC,         32'h1111_000C, 0);
    vecs[15] = mk(0, 32'h0,          1, 0, 32'h0,         0, 0,  1, 32'h200,       0, 32'hC,         32'h1111_000C, 0);
    vecs[16] = mk(1, 32'h1111_0200,  1, 0, 32'h0,         0, 0,  1, 32'h200,       0, 32'hC,         32'h1111_000C, 0);
    // trap and redirect together; then redirect coinciding with ack; wrap
    vecs[17] = mk(0, 32'h0,          1, 1, 32'h300,       1, 0,  1, 32'h204,       1, 32'h200,       32'h1111_0200, 0);
    vecs[18] = mk(1, 32'hBADB_AD00,  1, 0, 32'h0,         0, 0,  1, 32'h204,       0, 32'h200,       32'h1111_0200, 0);
    vecs[19] = mk(1, 32'h1111_0100,  1, 0, 32'h0,         0, 0,  1, 32'h100,       0, 32'h200,       32'h1111_0200, 0);
    vecs[20] = mk(1, 32'h0BAD_0104,  1, 1, 32'hFFFF_FFFF, 0, 0,  1, 32'h104,       1, 32'h100,       32'h1111_0100, 0);
    vecs[21] = mk(1, 32'h1111_FFFC,  1, 0, 32'h0,         0, 0,  1, 32'hFFFF_FFFC, 0, 32'h100,       32'h1111_0100, 0);
    vecs[22] = mk(0, 32'h0,          1, 0, 32'h0,         0, 0,  1, 32'h0,         1, 32'hFFFF_FFFC, 32'h1111_FFFC, 0);
    // halt during an outstanding request
    vecs[23] = mk(0, 32'h0,          1, 0, 32'h0,         0, 1,  1, 32'h0,         0, 32'hFFFF_FFFC, 32'h1111_FFFC, 0);
    vecs[24] = mk(1, 32'h2222_0000,  1, 0, 32'h0,         0, 1,  1, 32'h0,         0, 32'hFFFF_FFFC, 32'h1111_FFFC, 0);
    vecs[25] = mk(0, 32'h0,          0, 0, 32'h0,         0, 1,  0, 32'h4,         1, 32'h0,         32'h2222_0000, 1);
    vecs[26] = mk(0, 32'h0,          0, 1, 32'h40,        0, 1,  0, 32'h4,         1, 32'h0,         32'h2222_0000, 1);
    vecs[27] = mk(0, 32'h0,          0, 0, 32'h0,         0, 1,  0, 32'h40,        0, 32'h0,         32'h2222_0000, 1);
    vecs[28] = mk(0, 32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h40,        0, 32'h0,         32'h2222_0000, 0);
    vecs[29] = mk(0, 32'h0,          1, 0, 32'h0,         0, 0,  1, 32'h40,        0, 32'h0,         32'h2222_0000, 0);
    vecs[30] = mk(0, 32'h0,          1, 0, 32'h0,         0, 0,  1, 32'h40,        0, 32'h0,         32'h2222_0000, 0);

    rst_o = '{req: 1'b0, addr: 32'h0, vld: 1'b0, id_pc: 32'h0, inst: 32'h0, halted: 1'b0};

    reset = 1'b1;
    drive('0);
    repeat (2) @(negedge clk);
    #1 check("reset_state", rst_o);

    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      reset = 1'b0;
      drive(vecs[v].i);
      #1 check($sformatf("vec%0d", v), vecs[v].o);
    end

    // Reset asserted while the request at 0x40 is still waiting.
    #2 reset = 1'b1;
    #1 check("reset_mid_wait", rst_o);

    @(negedge clk);
    reset = 1'b0;
    drive('{ack: 1'b0, rdata: 32'h0, rdy: 1'b1, redir: 1'b0, rpc: 32'h0, trap: 1'b0, halt: 1'b0});
    #1 check("boot_after_reset", rst_o);
    @(negedge clk);
    #1 check("fetch_after_boot",
             '{req: 1'b1, addr: 32'h0, vld: 1'b0, id_pc: 32'h0, inst: 32'h0, halted: 1'b0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
